// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   lsu_state_e : access sequencer states
//   F3_*        : funct3 size/sign encodings for loads and stores
package mem_stage_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/mem_stage_lsu_if.sv
// req/gnt/rvalid data bus between the LSU and memory.
//   master : LSU side   (drives request, address, strobes, write data)
//   slave  : memory side (drives gnt, rvalid, read data)
interface mem_stage_lsu_if #(
    parameter int unsigned XLEN = 32
);
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [3:0]      mem_wstrb;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Combinational lane logic for the LSU.
//   addr_lo, funct3, is_store, wdata -> wstrb, wdata_lane, bad (misaligned/illegal)
//   addr_lo, funct3, rdata           -> ld_ext (sign/zero-extended load value)
module mem_stage_lsu_align
    import mem_stage_lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    input  logic            is_store,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      wstrb,
    output logic [XLEN-1:0] wdata_lane,
    output logic            bad,
    output logic [XLEN-1:0] ld_ext
);
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        wstrb      = '0;
        wdata_lane = '0;
        bad        = 1'b0;
        case (funct3)
            F3_B: begin
                wstrb      = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            F3_H: begin
                bad        = addr_lo[0];
                wstrb      = 4'b0011 << addr_lo;
                wdata_lane = {2{wdata[15:0]}};
            end
            F3_W: begin
                bad        = (addr_lo != 2'b00);
                wstrb      = 4'b1111;
                wdata_lane = wdata;
            end
            // Unsigned variants exist only for loads
            F3_BU:   bad = is_store;
            F3_HU:   bad = is_store | addr_lo[0];
            default: bad = 1'b1;
        endcase
    end

    always_comb begin
        rd_byte = rdata[{addr_lo, 3'b000} +: 8];
        rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        ld_ext  = '0;
        case (funct3)
            F3_B:    ld_ext = {{(XLEN-8){rd_byte[7]}}, rd_byte};
            F3_H:    ld_ext = {{(XLEN-16){rd_half[15]}}, rd_half};
            F3_W:    ld_ext = rdata;
            F3_BU:   ld_ext = {{(XLEN-8){1'b0}}, rd_byte};
            F3_HU:   ld_ext = {{(XLEN-16){1'b0}}, rd_half};
            default: ld_ext = '0;
        endcase
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: sequences one bus access per EX/MEM entry,
// stalls the pipeline until it completes, and returns extended load data.
//   clk, rst                         : clock, asynchronous active-high reset
//   ex_valid/ex_mem_rd/ex_mem_wr     : EX/MEM entry valid, load, store
//   ex_funct3/ex_addr/ex_wdata       : size/sign field, byte address, store data
//   stall_mem                        : hold IF/ID/EX/MEM registers
//   ld_data/ld_valid                 : extended load result and its 1-cycle strobe
//   access_err                       : 1-cycle pulse, misaligned or illegal access
//   bus_err                          : 1-cycle pulse, bus timeout
//   bus                              : req/gnt/rvalid data bus (master side)
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_mem_rd,
    input  logic            ex_mem_wr,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_addr,
    input  logic [XLEN-1:0] ex_wdata,
    output logic            stall_mem,
    output logic [XLEN-1:0] ld_data,
    output logic            ld_valid,
    output logic            access_err,
    output logic            bus_err,
    mem_stage_lsu_if.master bus
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    lsu_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       acc_f3;
    logic [1:0]       acc_lo;
    logic             acc_load;

    logic             idle;
    logic             req_any;
    logic             both;
    logic             accept;
    logic             timeout_hit;
    logic [1:0]       sel_lo;
    logic [2:0]       sel_f3;
    logic             sel_store;
    logic [3:0]       a_wstrb;
    logic [XLEN-1:0]  a_wdata;
    logic [XLEN-1:0]  a_ext;
    logic             a_bad;

    // In IDLE the aligner checks the incoming entry; afterwards it extends
    // read data using the size/lane captured at accept.
    assign idle      = (state == IDLE);
    assign sel_lo    = idle ? ex_addr[1:0] : acc_lo;
    assign sel_f3    = idle ? ex_funct3 : acc_f3;
    assign sel_store = idle ? ex_mem_wr : ~acc_load;

    mem_stage_lsu_align #(.XLEN(XLEN)) u_align (
        .addr_lo    (sel_lo),
        .funct3     (sel_f3),
        .is_store   (sel_store),
        .wdata      (ex_wdata),
        .rdata      (bus.mem_rdata),
        .wstrb      (a_wstrb),
        .wdata_lane (a_wdata),
        .bad        (a_bad),
        .ld_ext     (a_ext)
    );

    assign req_any     = ex_valid & (ex_mem_rd | ex_mem_wr);
    assign both        = ex_mem_rd & ex_mem_wr;
    assign accept      = idle & req_any & ~both & ~a_bad;
    assign access_err  = idle & req_any & (both | a_bad);
    assign stall_mem   = accept | (state == REQ) | (state == WAIT);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            acc_f3        <= '0;
            acc_lo        <= '0;
            acc_load      <= 1'b0;
            ld_data       <= '0;
            ld_valid      <= 1'b0;
            bus_err       <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wstrb <= '0;
            bus.mem_wdata <= '0;
        end else begin
            ld_valid <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state         <= REQ;
                        cnt           <= '0;
                        acc_f3        <= ex_funct3;
                        acc_lo        <= ex_addr[1:0];
                        acc_load      <= ex_mem_rd;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= ex_mem_wr;
                        bus.mem_addr  <= {ex_addr[XLEN-1:2], 2'b00};
                        bus.mem_wstrb <= ex_mem_wr ? a_wstrb : 4'b0000;
                        bus.mem_wdata <= ex_mem_wr ? a_wdata : '0;
                    end
                end
                REQ: begin
                    if (bus.mem_gnt || timeout_hit) begin
                        bus.mem_req   <= 1'b0;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= '0;
                        bus.mem_wstrb <= '0;
                        bus.mem_wdata <= '0;
                    end
                    // A granted store completes even on the last budget cycle;
                    // a granted load must still fit its response in the budget.
                    if (bus.mem_gnt && !acc_load) begin
                        state <= DONE;
                    end else if (timeout_hit) begin
                        state   <= DONE;
                        bus_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (bus.mem_gnt) state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        state    <= DONE;
                        ld_data  <= a_ext;
                        ld_valid <= 1'b1;
                    end else if (timeout_hit) begin
                        state   <= DONE;
                        bus_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    ld_data <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu (TIMEOUT_CYCLES=8). Inputs change on the
// falling edge; outputs are sampled 1 ns later.
module tb_mem_stage_lsu;
    import mem_stage_lsu_pkg::*;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic        stall_mem;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic        access_err;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;

    mem_stage_lsu_if #(.XLEN(32)) bus ();

    mem_stage_lsu #(
        .XLEN           (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_mem_rd  (ex_mem_rd),
        .ex_mem_wr  (ex_mem_wr),
        .ex_funct3  (ex_funct3),
        .ex_addr    (ex_addr),
        .ex_wdata   (ex_wdata),
        .stall_mem  (stall_mem),
        .ld_data    (ld_data),
        .ld_valid   (ld_valid),
        .access_err (access_err),
        .bus_err    (bus_err),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        ex_valid  = v;
        ex_mem_rd = rd;
        ex_mem_wr = wr;
        ex_funct3 = f3;
        ex_addr   = a;
        ex_wdata  = wd;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_stall"},  32'(stall_mem),     32'h0);
        chk({tag, "_lddata"}, ld_data,            32'h0);
        chk({tag, "_ldvld"},  32'(ld_valid),      32'h0);
        chk({tag, "_acerr"},  32'(access_err),    32'h0);
        chk({tag, "_buserr"}, 32'(bus_err),       32'h0);
        chk({tag, "_req"},    32'(bus.mem_req),   32'h0);
        chk({tag, "_we"},     32'(bus.mem_we),    32'h0);
        chk({tag, "_addr"},   bus.mem_addr,       32'h0);
        chk({tag, "_wstrb"},  32'(bus.mem_wstrb), 32'h0);
        chk({tag, "_wdata"},  bus.mem_wdata,      32'h0);
    endtask

    // Store with grant in the first REQ cycle
    task automatic store_imm(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] exp_addr,
                             input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
        int stalls = 0;
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, f3, a, wd);
        bus.mem_gnt = 1'b1;
        #1;
        stalls += int'(stall_mem);
        chk({tag, "_idle_req"}, 32'(bus.mem_req), 32'h0);
        @(negedge clk);
        #1;
        stalls += int'(stall_mem);
        chk({tag, "_req"},   32'(bus.mem_req),   32'h1);
        chk({tag, "_we"},    32'(bus.mem_we),    32'h1);
        chk({tag, "_addr"},  bus.mem_addr,       exp_addr);
        chk({tag, "_wstrb"}, 32'(bus.mem_wstrb), 32'(exp_strb));
        chk({tag, "_wdata"}, bus.mem_wdata,      exp_wdata);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        bus.mem_gnt = 1'b0;
        #1;
        stalls += int'(stall_mem);
        chk({tag, "_done_req"}, 32'(bus.mem_req), 32'h0);
        chk({tag, "_done_ldv"}, 32'(ld_valid),    32'h0);
        chk({tag, "_stalls"},   32'(stalls),      32'd2);
    endtask

    // Load with grant in the first REQ cycle and rvalid in the next cycle
    task automatic load_imm(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] rdata, input logic [31:0] exp_data);
        int stalls = 0;
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, f3, a, 32'h0);
        bus.mem_gnt = 1'b1;
        #1;
        stalls += int'(stall_mem);
        @(negedge clk);
        #1;
        stalls += int'(stall_mem);
        chk({tag, "_req"},   32'(bus.mem_req),   32'h1);
        chk({tag, "_we"},    32'(bus.mem_we),    32'h0);
        chk({tag, "_wstrb"}, 32'(bus.mem_wstrb), 32'h0);
        @(negedge clk);
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        #1;
        stalls += int'(stall_mem);
        chk({tag, "_wait_req"}, 32'(bus.mem_req), 32'h0);
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        stalls += int'(stall_mem);
        chk({tag, "_ldvalid"}, 32'(ld_valid), 32'h1);
        chk({tag, "_lddata"},  ld_data,       exp_data);
        @(negedge clk);
        #1;
        chk({tag, "_after_ldv"}, 32'(ld_valid), 32'h0);
        chk({tag, "_after_ldd"}, ld_data,       32'h0);
        chk({tag, "_stalls"},    32'(stalls),   32'd3);
    endtask

    // Rejected access: error pulse only, no stall, no bus activity
    task automatic err_case(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] a);
        @(negedge clk);
        drive(1'b1, rd, wr, f3, a, 32'hFFFF_FFFF);
        #1;
        chk({tag, "_acerr"}, 32'(access_err),  32'h1);
        chk({tag, "_stall"}, 32'(stall_mem),   32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        chk({tag, "_acerr_off"}, 32'(access_err), 32'h0);
        chk({tag, "_req"},       32'(bus.mem_req), 32'h0);
        chk({tag, "_stall_off"}, 32'(stall_mem),  32'h0);
    endtask

    initial begin
        int req_cycles;
        rst            = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;

        @(negedge clk);
        #1;
        chk_quiet("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_quiet("post_reset");

        // Idle with stray rvalid and no request
        @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1234_5678;
        #1;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        #1;
        chk_quiet("idle_stray_rvalid");

        store_imm("sb_103", F3_B, 32'h0000_0103, 32'h0000_00A5, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5);
        store_imm("sb_001", F3_B, 32'h0000_0001, 32'h0000_0077, 32'h0000_0000, 4'b0010, 32'h7777_7777);
        store_imm("sh_102", F3_H, 32'h0000_0102, 32'h1234_BEEF, 32'h0000_0100, 4'b1100, 32'hBEEF_BEEF);
        store_imm("sw_204", F3_W, 32'h0000_0204, 32'hDEAD_BEEF, 32'h0000_0204, 4'b1111, 32'hDEAD_BEEF);

        load_imm("lb_102",  F3_B,  32'h0000_0102, 32'h0080_0000, 32'hFFFF_FF80);
        load_imm("lbu_102", F3_BU, 32'h0000_0102, 32'h0080_0000, 32'h0000_0080);
        load_imm("lb_100",  F3_B,  32'h0000_0100, 32'h0000_007F, 32'h0000_007F);
        load_imm("lb_103",  F3_B,  32'h0000_0103, 32'hC300_0000, 32'hFFFF_FFC3);
        load_imm("lh_102",  F3_H,  32'h0000_0102, 32'h8001_0000, 32'hFFFF_8001);
        load_imm("lhu_102", F3_HU, 32'h0000_0102, 32'h8001_0000, 32'h0000_8001);
        load_imm("lh_100",  F3_H,  32'h0000_0100, 32'hFFFF_7FFF, 32'h0000_7FFF);
        load_imm("lw_104",  F3_W,  32'h0000_0104, 32'h1234_5678, 32'h1234_5678);

        err_case("lh_101",   1'b1, 1'b0, F3_H,   32'h0000_0101);
        err_case("lw_102",   1'b1, 1'b0, F3_W,   32'h0000_0102);
        err_case("sw_101",   1'b0, 1'b1, F3_W,   32'h0000_0101);
        err_case("sh_103",   1'b0, 1'b1, F3_H,   32'h0000_0103);
        err_case("lhu_103",  1'b1, 1'b0, F3_HU,  32'h0000_0103);
        err_case("ld_f3_3",  1'b1, 1'b0, 3'b011, 32'h0000_0000);
        err_case("st_f3_4",  1'b0, 1'b1, 3'b100, 32'h0000_0000);
        err_case("rd_and_wr", 1'b1, 1'b1, F3_W,  32'h0000_0000);

        // LW, grant after three waiting REQ cycles, rvalid two cycles after grant
        req_cycles = 0;
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, F3_W, 32'h0000_0040, 32'h0);
        #1;
        chk("lwd_accept_stall", 32'(stall_mem), 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            req_cycles += int'(bus.mem_req);
            chk("lwd_req_stall", 32'(stall_mem), 32'h1);
        end
        @(negedge clk);
        bus.mem_gnt = 1'b1;
        #1;
        req_cycles += int'(bus.mem_req);
        chk("lwd_addr", bus.mem_addr, 32'h0000_0040);
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        #1;
        req_cycles += int'(bus.mem_req);
        chk("lwd_wait1_stall", 32'(stall_mem), 32'h1);
        @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hCAFE_F00D;
        #1;
        req_cycles += int'(bus.mem_req);
        chk("lwd_wait2_stall", 32'(stall_mem), 32'h1);
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        chk("lwd_done_stall", 32'(stall_mem),  32'h0);
        chk("lwd_ldvalid",    32'(ld_valid),   32'h1);
        chk("lwd_lddata",     ld_data,         32'hCAFE_F00D);
        chk("lwd_req_cycles", 32'(req_cycles), 32'd4);

        // Store whose grant never arrives: 8 REQ cycles, then bus_err
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, F3_W, 32'h0000_0300, 32'h5555_AAAA);
        #1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            #1;
            chk("sto_req",   32'(bus.mem_req), 32'h1);
            chk("sto_stall", 32'(stall_mem),   32'h1);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        chk("sto_buserr", 32'(bus_err),     32'h1);
        chk("sto_stall0", 32'(stall_mem),   32'h0);
        chk("sto_ldv",    32'(ld_valid),    32'h0);
        chk("sto_req0",   32'(bus.mem_req), 32'h0);
        @(negedge clk);
        #1;
        chk("sto_buserr_pulse", 32'(bus_err), 32'h0);

        // Load granted at once whose rvalid never arrives
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, F3_W, 32'h0000_0000, 32'h0);
        bus.mem_gnt = 1'b1;
        #1;
        @(negedge clk);
        #1;
        chk("lto_req", 32'(bus.mem_req), 32'h1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.mem_gnt = 1'b0;
            #1;
            chk("lto_wait_stall", 32'(stall_mem), 32'h1);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        chk("lto_buserr", 32'(bus_err),   32'h1);
        chk("lto_ldv",    32'(ld_valid),  32'h0);
        chk("lto_lddata", ld_data,        32'h0);
        chk("lto_stall0", 32'(stall_mem), 32'h0);

        // Reset while REQ is pending: request drops before any clock edge
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, F3_W, 32'h0000_0040, 32'h0);
        #1;
        @(negedge clk);
        #1;
        chk("rreq_req_before", 32'(bus.mem_req), 32'h1);
        #2;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        chk("rreq_req_async", 32'(bus.mem_req), 32'h0);
        chk("rreq_stall",     32'(stall_mem),   32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_quiet("rreq_after");

        // Reset while WAITing, then a late rvalid that must be dropped
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, F3_W, 32'h0000_0080, 32'h0);
        bus.mem_gnt = 1'b1;
        #1;
        @(negedge clk);
        #1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        #1;
        chk("rwait_stall_before", 32'(stall_mem), 32'h1);
        #2;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        chk("rwait_stall_async", 32'(stall_mem), 32'h0);
        @(negedge clk);
        rst            = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hFFFF_FFFF;
        #1;
        chk_quiet("rwait_late_rvalid");
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        #1;
        chk_quiet("rwait_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
